// File: rtl/ftdi_pkg.sv
// Shared types and helpers for the FT232H 245-synchronous FIFO bus engines.
package ftdi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_TURN  = 3'd2,
        ST_WRITE = 3'd3,
        ST_REL   = 3'd4
    } tx_state_t;

    localparam int TURN_CYCLES = 1;

    // FTDI latches FU_D at an edge where both strobes were low beforehand.
    function automatic logic accepted(input logic wr_n, input logic txe_n);
        return !wr_n && !txe_n;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular byte buffer with wrap-bit pointers.
module sync_fifo #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] head,
    output logic [DW-1:0] head_nxt,
    output logic [AW:0]   fill,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);

    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] rd_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rd_idx   = rd_ptr[AW-1:0];
    assign head     = mem[rd_idx];
    // Lets the owner preload the post-pop head in the same edge as a pop.
    assign head_nxt = mem[rd_idx + IDX_ONE];
    assign fill     = wr_ptr - rd_ptr;
    assign full     = fill[AW];
    assign empty    = (fill == '0);

endmodule

// File: rtl/ftdi_sync_tx.sv
// FT232H 245-sync write engine: buffers producer bytes, bursts them
// onto FU_D under bus grant and flushes short packets via SIWU#.
module ftdi_sync_tx
    import ftdi_pkg::*;
#(
    parameter int FIFO_AW   = 4,
    parameter int FLUSH_TMO = 256,
    parameter int MAX_BURST = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         d,
    input  logic               d_vld,
    output logic               d_rdy,
    output logic               bus_req,
    input  logic               bus_gnt,
    input  logic               txe_n,
    output logic               wr_n,
    output logic               siwu_n,
    output logic [7:0]         dq,
    output logic               dq_oe,
    output logic [FIFO_AW:0]   fill
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(FLUSH_TMO);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [TW-1:0] TMO_LAST  = TW'(FLUSH_TMO - 1);

    tx_state_t      state;
    logic [BW-1:0]  burst_cnt;
    logic [BW-1:0]  burst_nxt;
    logic [TW-1:0]  tmo_cnt;
    logic           flush_pend;
    logic           accept;
    logic           push;
    logic           full;
    logic           empty;
    logic [7:0]     head;
    logic [7:0]     head_nxt;
    logic [FIFO_AW:0] fill_ap;
    logic           wr_go;
    logic           leave;

    sync_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (accept),
        .wdata    (d),
        .head     (head),
        .head_nxt (head_nxt),
        .fill     (fill),
        .full     (full),
        .empty    (empty)
    );

    assign accept    = accepted(wr_n, txe_n);
    assign push      = d_vld && !full;
    assign d_rdy     = !full;
    assign fill_ap   = fill - (FIFO_AW + 1)'(accept);
    assign burst_nxt = burst_cnt + BW'(accept);
    assign wr_go     = (fill_ap != '0) && !txe_n
                       && (burst_nxt < BURST_MAX) && bus_gnt;
    assign leave     = (fill_ap == '0) || (burst_nxt == BURST_MAX)
                       || !bus_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wr_n       <= 1'b1;
            siwu_n     <= 1'b1;
            dq         <= '0;
            dq_oe      <= 1'b0;
            bus_req    <= 1'b0;
            burst_cnt  <= '0;
            tmo_cnt    <= '0;
            flush_pend <= 1'b0;
        end else begin
            siwu_n <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        state   <= ST_REQ;
                        bus_req <= 1'b1;
                    end else if (flush_pend) begin
                        if (tmo_cnt == TMO_LAST) begin
                            siwu_n     <= 1'b0;
                            flush_pend <= 1'b0;
                            tmo_cnt    <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_gnt) begin
                        state <= ST_TURN;
                        dq_oe <= 1'b1;
                        dq    <= head;
                    end
                end
                ST_TURN: begin
                    state <= ST_WRITE;
                    wr_n  <= !wr_go;
                end
                ST_WRITE: begin
                    dq <= accept ? head_nxt : head;
                    if (leave) begin
                        state     <= ST_REL;
                        wr_n      <= 1'b1;
                        dq_oe     <= 1'b0;
                        bus_req   <= 1'b0;
                        burst_cnt <= '0;
                    end else begin
                        wr_n      <= !wr_go;
                        burst_cnt <= burst_nxt;
                    end
                end
                ST_REL: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            // Any traffic restarts the idle window before the flush.
            if (accept) flush_pend <= 1'b1;
            if (accept || push) tmo_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_ftdi_sync_tx.sv
// Bench for ftdi_sync_tx: queue model of the buffer and FTDI handshake,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_ftdi_sync_tx;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int TMO   = 256;
    localparam int MB    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    d = '0;
    logic          d_vld = 1'b0;
    logic          d_rdy;
    logic          bus_req;
    logic          bus_gnt = 1'b0;
    logic          txe_n = 1'b1;
    logic          wr_n;
    logic          siwu_n;
    logic [7:0]    dq;
    logic          dq_oe;
    logic [AW:0]   fill;

    always #5 clk = ~clk;

    ftdi_sync_tx #(
        .FIFO_AW   (AW),
        .FLUSH_TMO (TMO),
        .MAX_BURST (MB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .d_vld   (d_vld),
        .d_rdy   (d_rdy),
        .bus_req (bus_req),
        .bus_gnt (bus_gnt),
        .txe_n   (txe_n),
        .wr_n    (wr_n),
        .siwu_n  (siwu_n),
        .dq      (dq),
        .dq_oe   (dq_oe),
        .fill    (fill)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    logic [7:0] q[$];
    logic [7:0] acc_dat[$];
    int         acc_cyc[$];
    int         push_cyc[$];
    int         siwu_cyc[$];
    int         cyc = 0;
    logic       p_rst = 1'b1;
    logic       p_txe = 1'b1;
    logic       p_gnt = 1'b0;
    logic       exp_siwu = 1'b1;
    bit         armed = 0;
    int         quiet = 0;
    int         bcnt = 0;

    // Model: snapshot each cycle between edges, check, then predict.
    always @(negedge clk) begin : cmp
        bit acc;
        bit psh;
        cyc++;
        if (p_rst) begin
            check("rst_wr_n", int'(wr_n), 1);
            check("rst_siwu_n", int'(siwu_n), 1);
            check("rst_dq", int'(dq), 0);
            check("rst_dq_oe", int'(dq_oe), 0);
            check("rst_bus_req", int'(bus_req), 0);
        end
        check("fill", int'(fill), q.size());
        check("d_rdy", int'(d_rdy), int'(q.size() < DEPTH));
        check("siwu_n", int'(siwu_n), int'(exp_siwu));
        if (!siwu_n) siwu_cyc.push_back(cyc);
        if (!p_rst && (p_txe || !p_gnt))
            check("wr_n_forced_high", int'(wr_n), 1);
        if (!wr_n) check("wr_owns_bus", int'({dq_oe, bus_req}), 3);
        if (dq_oe && q.size() > 0) check("dq_head", int'(dq), int'(q[0]));
        if (!dq_oe) bcnt = 0;
        exp_siwu = 1'b1;
        if (rst) begin
            q.delete();
            armed = 0;
            quiet = 0;
            bcnt  = 0;
        end else begin
            acc = !wr_n && !txe_n;
            psh = d_vld && (q.size() < DEPTH);
            if (acc) begin
                check("accept_nonempty", int'(q.size() > 0), 1);
                acc_dat.push_back(dq);
                acc_cyc.push_back(cyc);
                if (q.size() > 0) void'(q.pop_front());
                bcnt++;
                check("burst_limit", int'(bcnt <= MB), 1);
            end
            if (psh) begin
                q.push_back(d);
                push_cyc.push_back(cyc);
            end
            if (acc) begin
                armed = (q.size() == 0);
                quiet = 0;
            end else if (psh) begin
                armed = 0;
            end else if (armed) begin
                quiet++;
                if (quiet == TMO + 1) begin
                    exp_siwu = 1'b0;
                    armed = 0;
                end
            end
        end
        p_rst = rst;
        p_txe = txe_n;
        p_gnt = bus_gnt;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push1(input logic [7:0] v);
        int t = 0;
        d = v;
        d_vld = 1'b1;
        while (!d_rdy && t < 400) begin
            step();
            t++;
        end
        if (t >= 400) check("push_timeout", 1, 0);
        step();
        d_vld = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int bound);
        int t = 0;
        while (acc_cyc.size() < n && t < bound) begin
            step();
            t++;
        end
        check("wait_accept", acc_cyc.size(), n);
    endtask

    task automatic wait_siwu(input int n, input int bound);
        int t = 0;
        while (siwu_cyc.size() < n && t < bound) begin
            step();
            t++;
        end
        check("wait_siwu", siwu_cyc.size(), n);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        int pbase;
        int sb;
        int a1;
        int t;
        int offs[10];
        offs = '{0, 1, 2, 3, 8, 9, 10, 11, 16, 17};

        step(3);
        @(negedge clk);
        check("reset_fill", int'(fill), 0);
        check("reset_d_rdy", int'(d_rdy), 1);
        check("reset_wr_n", int'(wr_n), 1);
        step();
        rst = 1'b0;

        // Three bytes, grant and TXE# ready
        bus_gnt = 1'b1;
        txe_n = 1'b0;
        base = acc_cyc.size();
        pbase = push_cyc.size();
        push1(8'h11);
        push1(8'h22);
        push1(8'h33);
        wait_acc(base + 3, 40);
        step(3);
        check("t1_byte0", int'(acc_dat[base]), 'h11);
        check("t1_byte1", int'(acc_dat[base + 1]), 'h22);
        check("t1_byte2", int'(acc_dat[base + 2]), 'h33);
        check("t1_latency", acc_cyc[base] - push_cyc[pbase], 4);
        check("t1_consec1", acc_cyc[base + 1] - acc_cyc[base], 1);
        check("t1_consec2", acc_cyc[base + 2] - acc_cyc[base], 2);
        check("t1_fill_end", int'(fill), 0);
        check("t1_released", int'({bus_req, dq_oe}), 0);

        // Five bytes with a 3-cycle TXE# stall after two accepts
        base = acc_cyc.size();
        for (int i = 0; i < 5; i++) push1(8'hA1 + 8'(i));
        wait_acc(base + 2, 40);
        txe_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_stall_dq", int'(dq), 'hA3);
            check("t2_stall_oe", int'(dq_oe), 1);
            step();
        end
        txe_n = 1'b0;
        wait_acc(base + 5, 60);
        step(20);
        check("t2_count", acc_cyc.size() - base, 5);
        for (int i = 0; i < 5; i++)
            check("t2_order", int'(acc_dat[base + i]), 'hA1 + i);

        // Fill to 16 with no grant, 17th byte held by producer
        bus_gnt = 1'b0;
        step(2);
        base = acc_cyc.size();
        for (int i = 0; i < 16; i++) push1(8'h40 + 8'(i));
        @(negedge clk);
        check("t3_full_fill", int'(fill), 16);
        check("t3_full_rdy", int'(d_rdy), 0);
        d = 8'h50;
        d_vld = 1'b1;
        step(2);
        check("t3_held_fill", int'(fill), 16);
        check("t3_held_bus", int'(bus_req), 1);
        bus_gnt = 1'b1;
        t = 0;
        while (!d_rdy && t < 40) begin
            step();
            t++;
        end
        check("t3_rdy_after_first", acc_cyc.size() - base, 1);
        step();
        d_vld = 1'b0;
        wait_acc(base + 17, 300);
        for (int i = 0; i < 16; i++)
            check("t3_order", int'(acc_dat[base + i]), 'h40 + i);
        check("t3_last", int'(acc_dat[base + 16]), 'h50);

        // Ten buffered bytes split into bursts of MAX_BURST
        bus_gnt = 1'b0;
        step(5);
        base = acc_cyc.size();
        for (int i = 0; i < 10; i++) push1(8'h60 + 8'(i));
        bus_gnt = 1'b1;
        wait_acc(base + 10, 100);
        for (int i = 0; i < 10; i++)
            check("t4_burst_slot", acc_cyc[base + i] - acc_cyc[base], offs[i]);

        // Grant dropped right after a first accept
        step(5);
        base = acc_cyc.size();
        for (int i = 0; i < 3; i++) push1(8'h90 + 8'(i));
        wait_acc(base + 1, 40);
        bus_gnt = 1'b0;
        step(6);
        check("t4g_accepted", acc_cyc.size() - base, 2);
        check("t4g_fill", int'(fill), 1);
        check("t4g_oe", int'(dq_oe), 0);
        bus_gnt = 1'b1;
        wait_acc(base + 3, 40);
        check("t4g_last", int'(acc_dat[base + 2]), 'h92);

        // Single byte then idle: one SIWU# pulse
        step(300);
        base = acc_cyc.size();
        push1(8'h77);
        wait_acc(base + 1, 40);
        sb = siwu_cyc.size();
        wait_siwu(sb + 1, 400);
        check("t5_flush_delay", siwu_cyc[sb] - acc_cyc[base], TMO + 2);
        step(3);
        check("t5_pulse_width", siwu_cyc.size(), sb + 1);

        // A push at tmo_cnt near 100 cancels the pending flush
        base = acc_cyc.size();
        push1(8'h78);
        wait_acc(base + 1, 40);
        a1 = acc_cyc[base];
        step(101);
        push1(8'h79);
        wait_acc(base + 2, 40);
        sb = siwu_cyc.size();
        wait_siwu(sb + 1, 400);
        check("t5_no_early", int'(siwu_cyc[sb] > a1 + TMO + 2), 1);
        check("t5_rearm_delay", siwu_cyc[sb] - acc_cyc[base + 1], TMO + 2);

        // Reset while a write strobe is active
        base = acc_cyc.size();
        for (int i = 0; i < 4; i++) push1(8'hC0 + 8'(i));
        t = 0;
        while (wr_n && t < 40) begin
            step();
            t++;
        end
        check("t6_in_write", int'(wr_n), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t6_wr_n", int'(wr_n), 1);
        check("t6_dq_oe", int'(dq_oe), 0);
        check("t6_bus_req", int'(bus_req), 0);
        check("t6_fill", int'(fill), 0);
        check("t6_siwu_n", int'(siwu_n), 1);
        check("t6_d_rdy", int'(d_rdy), 1);
        step(5);
        check("t6_idle_req", int'(bus_req), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
